sd_spi_master: RTL and testbench
================================

# sd_spi_master

SPI master engine for the SD-card path of the DivMMC interface. It sits directly downstream of the Z80 port decoder for the SPI data port 0xEB. The decoder hands it one byte per port access; this block shifts the byte out in SPI mode 0, returns the received byte, and throttles the CPU through WAIT when accesses arrive faster than the link drains. The clock rate is programmable, with a slow rate for card initialisation (<400 kHz) and a fast rate for data transfer.

## Interface
Parameters:
- FAST_DIV, 0: half-period of SCK in `clock` cycles minus one, used when `slow_mode`=0.
- SLOW_DIV, 63: half-period of SCK in `clock` cycles minus one, used when `slow_mode`=1. Width 8 bits.

Ports:
- clock  in  1  system clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-low.
- start  in  1  one-cycle strobe from the port decoder: transfer `tx_data`.
- tx_data  in  8  byte to send; sampled in the cycle `start`=1.
- slow_mode  in  1  divider select; sampled when a transfer is loaded.
- clr_ovr  in  1  synchronous clear of `overrun`.
- spi_miso  in  1  card data out.
- spi_sck  out  1  SPI clock; idles low.
- spi_mosi  out  1  SPI data to card; idles high.
- rx_data  out  8  last received byte; held until the next completion.
- busy  out  1  a transfer is active.
- done  out  1  one-cycle pulse on completion.
- wait_n  out  1  Z80 WAIT, low while the pending slot is full.
- overrun  out  1  sticky flag: a `start` was dropped.

## Operation
- Reset values: `spi_sck`=0, `spi_mosi`=1, `rx_data`=8'hFF, `busy`=0, `done`=0, `wait_n`=1, `overrun`=0. The state is IDLE and the pending slot is empty.
- States:
  - IDLE: on `start`, load the shift register with `tx_data`, latch D = `slow_mode` ? SLOW_DIV : FAST_DIV, clear the half-period counter and the bit counter (3 bits), then go to XFER.
  - XFER: runs 16 half-periods of D+1 clocks each.
    - Odd half-periods end with SCK rising; `spi_miso` is shifted into the rx register on that edge.
    - Even half-periods end with SCK falling; the tx register shifts left with 1 fill, and `spi_mosi` is driven from tx[7].
    - On the edge ending half-period 16:
      - `rx_data` is updated and `done`=1 for the next cycle.
      - If the pending slot is full, the pending byte is loaded (with `slow_mode` resampled) and the block stays in XFER.
      - Otherwise it returns to IDLE, `busy`=0, and `spi_mosi`=1.
- Pending slot (1 byte):
  - `start` while busy with the slot empty: store the byte and set slot full.
  - `start` while the slot is full: drop the byte and set `overrun`.
  - `clr_ovr` clears `overrun`. If `clr_ovr` and a dropping `start` occur in the same cycle, set wins.
- `wait_n` = ~slot_full, registered.
- Divider width and counters: the half-period counter is 8 bits and compares against D with no wrap beyond D. The bit counter wraps 7→0 only at completion.

## Timing
- Start edge E0 (the edge where `start`=1 is sampled): `busy`=1 and MOSI = tx[7] are visible after E0.
- SCK rises at edge E0+(D+1)·(2k+1) and falls at E0+(D+1)·(2k+2), for k=0..7.
- Completion edge is E0+16(D+1). `done` is high for exactly one cycle after it, and `busy` drops after it unless back-to-back.
- Back-to-back: there is no idle cycle between bytes, and SCK stays low across the boundary.
- `start` on the completion edge with the slot empty starts the new transfer immediately. No drop, `overrun` unchanged.
- `start` on the completion edge with the slot full: the pending byte becomes active and the new byte fills the slot. No overrun.
- `wait_n` goes low the cycle after the slot fills. It goes high the cycle after the completion edge that empties the slot.
- Reset asserted mid-transfer aborts immediately to reset values, the pending slot is discarded, and SCK is not completed.

## Test plan
- Reset, FAST_DIV=0: `start` with tx=8'hA5, miso loopback to mosi → MOSI bits 1,0,1,0,0,1,0,1; `done` 16 clocks after E0; `rx_data`=8'hA5; `busy` high for 16 cycles.
- `slow_mode`=1, SLOW_DIV=63, tx=8'h40, miso tied 0 → SCK period 128 clocks; `done` at E0+1024; `rx_data`=8'h00.
- Two `start`s 3 cycles apart (8'h12, 8'h34), D=0 → `wait_n` low from cycle 4 to cycle 17; second byte starts at edge 16 with no gap; two `done` pulses at 16 and 32; no `overrun`.
- Three `start`s within 5 cycles → third is dropped and `overrun`=1; `clr_ovr` pulse → `overrun`=0.
- `start` exactly on the completion edge of a single transfer → new transfer continuous; `busy` never drops.
- Assert reset at half-period 7 → outputs return to reset values asynchronously; subsequent transfer of 8'hFF returns miso data correctly.

Source files
------------

// File: rtl/sd_spi_master.sv
// SPI mode-0 master for the DivMMC SD-card data port: one byte per start strobe,
// with a one-byte pending slot that throttles the Z80 through WAIT when it is full.
module sd_spi_master #(
  parameter int FAST_DIV = 0,
  parameter int SLOW_DIV = 63
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] tx_data,
  input  logic       slow_mode,
  input  logic       clr_ovr,
  input  logic       spi_miso,
  output logic       spi_sck,
  output logic       spi_mosi,
  output logic [7:0] rx_data,
  output logic       busy,
  output logic       done,
  output logic       wait_n,
  output logic       overrun,
  output logic       dbg_state
);

  // Handshake: start is a one-cycle request with no ready; flow control is wait_n
  // (low while the pending slot is occupied), and a start seen with the slot full is dropped.
  typedef enum logic {
    S_IDLE = 1'b0,
    S_XFER = 1'b1
  } state_t;

  localparam logic [7:0] LP_FAST = 8'(FAST_DIV);
  localparam logic [7:0] LP_SLOW = 8'(SLOW_DIV);

  state_t     r_state;
  state_t     w_state_next;
  logic [7:0] r_cnt;
  logic [7:0] r_div;
  logic [2:0] r_bit;
  logic [7:0] r_tx;
  logic [7:0] r_rx;
  logic [7:0] r_slot;
  logic       r_slot_full;
  logic       r_sck;
  logic       r_mosi;
  logic [7:0] r_rx_data;
  logic       r_done;
  logic       r_wait_n;
  logic       r_ovr;

  logic       w_hp_end;
  logic       w_last;
  logic       w_load_pend;
  logic       w_load_new;
  logic       w_load;
  logic [7:0] w_load_byte;
  logic       w_fill;
  logic       w_drop;
  logic [7:0] w_new_div;

  always_comb begin
    w_hp_end     = 1'b0;
    w_last       = 1'b0;
    w_load_pend  = 1'b0;
    w_load_new   = 1'b0;
    w_load       = 1'b0;
    w_load_byte  = tx_data;
    w_fill       = 1'b0;
    w_drop       = 1'b0;
    w_new_div    = slow_mode ? LP_SLOW : LP_FAST;
    w_state_next = r_state;

    w_hp_end    = (r_state == S_XFER) && (r_cnt == r_div);
    // The sixteenth half-period is the falling edge after the eighth bit.
    w_last      = w_hp_end && r_sck && (r_bit == 3'd7);
    w_load_pend = w_last && r_slot_full;
    w_load_new  = start && ((r_state == S_IDLE) || (w_last && !r_slot_full));
    w_load      = w_load_pend || w_load_new;
    w_load_byte = w_load_pend ? r_slot : tx_data;
    w_fill      = start && (r_state == S_XFER) && !w_load_new && (!r_slot_full || w_last);
    w_drop      = start && (r_state == S_XFER) && r_slot_full && !w_last;

    unique case (r_state)
      S_IDLE: if (start) w_state_next = S_XFER;
      S_XFER: if (w_last && !w_load) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_cnt       <= 8'd0;
      r_div       <= 8'd0;
      r_bit       <= 3'd0;
      r_tx        <= 8'hFF;
      r_rx        <= 8'hFF;
      r_slot      <= 8'h00;
      r_slot_full <= 1'b0;
      r_sck       <= 1'b0;
      r_mosi      <= 1'b1;
      r_rx_data   <= 8'hFF;
      r_done      <= 1'b0;
      r_wait_n    <= 1'b1;
      r_ovr       <= 1'b0;
    end else begin
      r_done   <= w_last;
      r_wait_n <= ~r_slot_full;
      if (w_last) r_rx_data <= r_rx;

      if (w_drop)       r_ovr <= 1'b1;
      else if (clr_ovr) r_ovr <= 1'b0;

      if (w_fill) begin
        r_slot      <= tx_data;
        r_slot_full <= 1'b1;
      end else if (w_load_pend) begin
        r_slot_full <= 1'b0;
      end

      if (w_load) begin
        r_tx   <= w_load_byte;
        r_mosi <= w_load_byte[7];
        r_div  <= w_new_div;
        r_cnt  <= 8'd0;
        r_bit  <= 3'd0;
        r_sck  <= 1'b0;
      end else if (w_last) begin
        r_sck  <= 1'b0;
        r_mosi <= 1'b1;
        r_cnt  <= 8'd0;
        r_bit  <= 3'd0;
      end else if (w_hp_end) begin
        r_cnt <= 8'd0;
        if (r_sck) begin
          r_sck  <= 1'b0;
          r_tx   <= {r_tx[6:0], 1'b1};
          r_mosi <= r_tx[6];
          r_bit  <= r_bit + 3'd1;
        end else begin
          r_sck <= 1'b1;
          r_rx  <= {r_rx[6:0], spi_miso};
        end
      end else if (r_state == S_XFER) begin
        r_cnt <= r_cnt + 8'd1;
      end
    end
  end

  assign spi_sck   = r_sck;
  assign spi_mosi  = r_mosi;
  assign rx_data   = r_rx_data;
  assign busy      = (r_state == S_XFER);
  assign done      = r_done;
  assign wait_n    = r_wait_n;
  assign overrun   = r_ovr;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_sd_spi_master.sv
// Bench for sd_spi_master: a cycle-timeline reference model predicts every output each
// cycle, and received bytes are checked through an expected queue popped on done.
module tb_sd_spi_master;
  localparam int FD = 0;
  localparam int SD = 63;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       slow_mode = 1'b0;
  logic       clr_ovr = 1'b0;
  logic       spi_miso;
  logic       spi_sck;
  logic       spi_mosi;
  logic [7:0] rx_data;
  logic       busy;
  logic       done;
  logic       wait_n;
  logic       overrun;
  logic       dbg_state;

  // 0: loopback, 1: tied low, 2: inverted loopback
  logic [1:0] miso_mode = 2'd0;

  sd_spi_master #(.FAST_DIV(FD), .SLOW_DIV(SD)) dut (
    .clock(clock), .reset(reset), .start(start), .tx_data(tx_data),
    .slow_mode(slow_mode), .clr_ovr(clr_ovr), .spi_miso(spi_miso),
    .spi_sck(spi_sck), .spi_mosi(spi_mosi), .rx_data(rx_data), .busy(busy),
    .done(done), .wait_n(wait_n), .overrun(overrun), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clock = ~clock;

  assign spi_miso = (miso_mode == 2'd0) ? spi_mosi :
                    (miso_mode == 2'd1) ? 1'b0 : ~spi_mosi;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_sck"}, 32'(spi_sck), 32'd0);
    chk({tag, "_mosi"}, 32'(spi_mosi), 32'd1);
    chk({tag, "_rx_data"}, 32'(rx_data), 32'hFF);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_wait_n"}, 32'(wait_n), 32'd1);
    chk({tag, "_overrun"}, 32'(overrun), 32'd0);
  endtask

  // reference model: transfers as time intervals on a cycle counter
  int         cyc = 0;
  bit         m_active = 1'b0;
  bit         m_pend = 1'b0;
  bit         m_ovr = 1'b0;
  bit         m_done = 1'b0;
  bit         m_wait = 1'b1;
  logic [7:0] m_tx = 8'hFF;
  logic [7:0] m_pend_tx = 8'h00;
  int         m_start = 0;
  int         m_end = 0;
  int         m_d = 0;
  logic [7:0] m_rx_hold = 8'hFF;
  logic [7:0] exp_q[$];

  function automatic logic [7:0] exp_rx_of(input logic [7:0] b);
    case (miso_mode)
      2'd0:    return b;
      2'd1:    return 8'h00;
      default: return ~b;
    endcase
  endfunction

  function automatic int div_of(input logic s);
    return s ? SD : FD;
  endfunction

  always @(posedge clock) begin
    if (!reset) begin
      m_active = 1'b0; m_pend = 1'b0; m_ovr = 1'b0; m_done = 1'b0; m_wait = 1'b1;
      exp_q.delete();
    end else begin
      bit drop;
      drop = 1'b0;
      cyc++;
      m_wait = !m_pend;
      m_done = 1'b0;
      if (m_active && cyc == m_end) begin
        m_done = 1'b1;
        if (m_pend) begin
          m_pend = 1'b0; m_tx = m_pend_tx; m_start = cyc;
          m_d = div_of(slow_mode); m_end = cyc + 16 * (m_d + 1);
        end else begin
          m_active = 1'b0;
        end
      end
      if (start) begin
        if (!m_active) begin
          m_active = 1'b1; m_tx = tx_data; m_start = cyc;
          m_d = div_of(slow_mode); m_end = cyc + 16 * (m_d + 1);
          exp_q.push_back(exp_rx_of(tx_data));
        end else if (!m_pend) begin
          m_pend = 1'b1; m_pend_tx = tx_data;
          exp_q.push_back(exp_rx_of(tx_data));
        end else begin
          drop = 1'b1;
        end
      end
      if (drop)         m_ovr = 1'b1;
      else if (clr_ovr) m_ovr = 1'b0;
    end
  end

  // scoreboard / monitor
  always @(negedge clock) begin
    if (!reset) begin
      m_rx_hold = 8'hFF;
    end else begin
      logic e_sck;
      logic e_mosi;
      int   h;
      int   idx;
      if (done) begin
        if (exp_q.size() == 0) chk("done_without_expected", 32'd1, 32'd0);
        else m_rx_hold = exp_q.pop_front();
      end
      e_sck = 1'b0;
      e_mosi = 1'b1;
      if (m_active) begin
        h = (cyc - m_start) / (m_d + 1);
        idx = 7 - h / 2;
        e_sck = h[0];
        e_mosi = m_tx[idx];
      end
      chk("busy", 32'(busy), 32'(m_active));
      chk("done", 32'(done), 32'(m_done));
      chk("wait_n", 32'(wait_n), 32'(m_wait));
      chk("overrun", 32'(overrun), 32'(m_ovr));
      chk("sck", 32'(spi_sck), 32'(e_sck));
      chk("mosi", 32'(spi_mosi), 32'(e_mosi));
      chk("rx_data", 32'(rx_data), 32'(m_rx_hold));
    end
  end

  // driver tasks
  task automatic drive(input logic st, input logic [7:0] d, input logic clr, input logic sm);
    @(negedge clock);
    #1;
    start = st; tx_data = d; clr_ovr = clr; slow_mode = sm;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  initial begin
    reset = 1'b0;
    repeat (3) @(negedge clock);
    #1;
    chk_reset_vals("por");
    reset = 1'b1;

    miso_mode = 2'd0;
    drive(1'b1, 8'hA5, 1'b0, 1'b0);
    idle(20);

    miso_mode = 2'd1;
    drive(1'b1, 8'h40, 1'b0, 1'b1);
    idle(1030);

    miso_mode = 2'd0;
    drive(1'b1, 8'h12, 1'b0, 1'b0);
    idle(2);
    drive(1'b1, 8'h34, 1'b0, 1'b0);
    idle(40);

    drive(1'b1, 8'h11, 1'b0, 1'b0);
    idle(1);
    drive(1'b1, 8'h22, 1'b0, 1'b0);
    idle(1);
    drive(1'b1, 8'h33, 1'b0, 1'b0);
    idle(40);
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    idle(3);

    // clear and drop in the same cycle: the drop keeps overrun set
    drive(1'b1, 8'h44, 1'b0, 1'b0);
    idle(1);
    drive(1'b1, 8'h55, 1'b0, 1'b0);
    idle(1);
    drive(1'b1, 8'h66, 1'b1, 1'b0);
    idle(40);
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    idle(3);

    // start exactly on the completion edge, slot empty
    drive(1'b1, 8'h5A, 1'b0, 1'b0);
    idle(15);
    drive(1'b1, 8'hC3, 1'b0, 1'b0);
    idle(40);

    // start exactly on the completion edge, slot full
    drive(1'b1, 8'h01, 1'b0, 1'b0);
    idle(2);
    drive(1'b1, 8'h02, 1'b0, 1'b0);
    idle(12);
    drive(1'b1, 8'h03, 1'b0, 1'b0);
    idle(60);

    // reset mid-transfer with a pending byte
    drive(1'b1, 8'h55, 1'b0, 1'b0);
    drive(1'b1, 8'h66, 1'b0, 1'b0);
    idle(5);
    @(negedge clock);
    #1;
    reset = 1'b0;
    #1;
    chk_reset_vals("async");
    repeat (2) @(negedge clock);
    #1;
    chk_reset_vals("held");
    reset = 1'b1;
    miso_mode = 2'd2;
    drive(1'b1, 8'hFF, 1'b0, 1'b0);
    idle(20);

    // randomized traffic
    miso_mode = 2'd0;
    for (int i = 0; i < 300; i++) begin
      drive(1'($urandom_range(0, 3) == 0), 8'($urandom),
            1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 19) == 0));
    end
    begin
      int guard;
      guard = 0;
      while (m_active && guard < 4000) begin
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        guard++;
      end
      chk("drain_timeout", 32'(m_active), 32'd0);
    end
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    idle(3);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
